max_bus_ctrl: RTL
=================

# max_bus_ctrl

Parametrised bus controller for the Commodore MAX core and its expanded-RAM variants. It replaces the loose PLA glue and fixed enables with a single block: one phase counter derived from `clk_cpu`, the CPU/VIC/pixel clock-enable pulses, BA-aware CPU stalling, a registered Ultimax memory-map decode with generic RAM size, the CPU read-data mux and the power-on reset stretcher. It sits between `cpu_6510` and the RAM, colour RAM, VIC, SID, CIA and cartridge ROMs.

## Interface
- `CLK_DIV`, 32: `clk_cpu` cycles per phi2 period; even, ≥8.
- `PIX_DIV`, 4: `clk_cpu` cycles per pixel enable; must divide `CLK_DIV`.
- `RAM_AW`, 11: main RAM address width, 11..15; RAM spans $0000..2^RAM_AW-1.
- `RST_CYCLES`, 255: `clk_cpu` cycles `sys_reset` is held after the last reset cause.
- `clk_cpu` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high (PLL-unlock OR button OR menu).
- `addr` in 16: CPU address.
- `we` in 1: CPU write strobe, high = write.
- `ba` in 1: VIC bus-available, low = VIC requests the bus.
- `ram_do`, `vic_do`, `sid_do`, `cia_do`, `roml_do`, `romh_do` in 8 each: source read data.
- `col_do` in 4: colour RAM read data.
- `sys_reset` out 1: stretched reset to all other blocks.
- `phi0` out 1: high during the CPU half-cycle.
- `cpu_en`, `vic_en`, `pix_en`, `io_rd` out 1 each: single-cycle enable pulses.
- `cs_ram`, `cs_col`, `cs_vic`, `cs_sid`, `cs_cia`, `cs_roml`, `cs_romh` out 1 each: registered chip selects, active-high.
- `ram_we`, `col_we`, `io_we` out 1 each: single-cycle write pulses.
- `cpu_di` out 8: registered read data to the CPU.

## Operation
- **Phase counter:** `ph` runs 0..CLK_DIV-1 and wraps. `phi0 = (ph >= CLK_DIV/2)`.
- **VIC and pixel enables:** `vic_en` pulses at `ph == CLK_DIV/2-1`. `pix_en` pulses when `ph % PIX_DIV == PIX_DIV-1`.
- **CPU enable:** `cpu_en` pulses at `ph == CLK_DIV-1` unless a stall applies.
- **Stall counter:** `ba_cnt` (2-bit, saturating at 3) counts `vic_en` pulses while `ba` is low. It clears when `ba` is high.
- **Stall rule:** while `ba` is low, reads stall immediately. Writes proceed only while `ba_cnt < 3`.
- **Decode (Ultimax map):** the cs registers load from `addr` at `ph == 0` and hold for the full period.
  - RAM: `addr < 2**RAM_AW`.
  - ROML: $8000-$9FFF.
  - VIC: $D000-$D3FF.
  - SID: $D400-$D7FF.
  - Colour RAM: $D800-$DBFF.
  - CIA: $DC00-$DCFF.
  - ROMH: $E000-$FFFF.
  - Everything else is unmapped, with no cs asserted.
  - Priority: the RAM range wins over all others.
- **Write pulses:** on the cycle `cpu_en` fires with `we` high:
  - `ram_we` if `cs_ram`;
  - `col_we` if `cs_col`;
  - `io_we` if any of `cs_vic`, `cs_sid`, `cs_cia`.
  - ROM writes are ignored.
- **`io_rd`:** equals `cpu_en & ~we & (cs_vic | cs_sid | cs_cia)`.
- **Read mux:** `cpu_di` registers at `ph == CLK_DIV-2` from the selected source.
  - Colour RAM returns `{cpu_di[7:4], col_do}`.
  - Unmapped reads hold the previous `cpu_di` (open bus).
- **Reset stretcher:** counter `rc` reloads to 0 while `reset` is high. It otherwise increments to `RST_CYCLES` and holds there. `sys_reset = (rc != RST_CYCLES)`.
- **While `sys_reset` is high:**
  - `ph` holds 0;
  - all enables and write pulses are 0;
  - all cs are 0.

## Timing
- **Reset values:**
  - `ph=0`, `phi0=0`, `ba_cnt=0`, `cpu_di=8'h00`;
  - all cs, enables and write pulses are 0;
  - `sys_reset=1`.
- **Release after reset:** `sys_reset` falls `RST_CYCLES+1` clocks after `reset` deasserts. The first `cpu_en` follows `CLK_DIV` clocks later.
- **Pipeline within one period:** address sampled at `ph == 0`, cs visible at `ph == 1`, data registered at `ph == CLK_DIV-2`, visible when `cpu_en` fires.
- **`reset` mid-operation:** takes effect at the next clock edge. Any pending pulse is suppressed.
- **`ba` edges:**
  - A `ba` rise takes effect on the next `cpu_en` slot.
  - A `ba` fall in the same cycle as `ph == CLK_DIV-1` stalls a read in that very slot.
- **Coincident pulses:** `pix_en` may coincide with `vic_en` or `cpu_en`; no pulse shadows another.

## Structure
- **Package `max_bus_pkg`:**
  - the address-range constants (base and mask per region);
  - a `cs_t` enum for the read-mux select;
  - the stall threshold 3.
- **Sub-module `max_clk_phase`:** phase counter, `phi0`, `vic_en`, `pix_en`.
- **Top `max_bus_ctrl`:** holds decode, stall, mux and reset logic.

## Test plan
- **Reset release:** `RST_CYCLES=255`, pulse `reset` 1 clock → `sys_reset` low exactly 256 clocks later. First `cpu_en` 32 clocks after that; `phi0` toggles every 16 clocks.
- **Decode sweep:** `addr` = $0000, $07FF, $0800, $8000, $D000, $D400, $D800, $DC00, $DD00, $E000 at `RAM_AW=11` → cs in order: ram, ram, none, roml, vic, sid, col, cia, none, romh. With `RAM_AW=15`, $0800 → ram and $8000 → roml.
- **Read and open bus:**
  - `ram_do`=$A5 at $0100 → `cpu_di`=$A5 at `cpu_en`.
  - Then colour read with `col_do`=$3 → $A3.
  - Then unmapped $0900 → $A3 held.
- **BA stall:** hold `ba` low for 5 periods.
  - Read sequence → no `cpu_en` during the low phase.
  - Write sequence → exactly 3 `cpu_en`/`io_we` pulses, then stall until `ba` rises.
- **Enables and write pulses:** with `CLK_DIV=8`, `PIX_DIV=2`, count 80 clocks → 10 `cpu_en`, 10 `vic_en`, 40 `pix_en`. A write to $D020 yields `io_we` in the same cycle as `cpu_en`.
- **Mid-operation reset:** assert `reset` at `ph == 30` during a RAM write → no `ram_we` is ever issued. All outputs return to their reset values on the next clock.

Source files
------------

// File: rtl/max_bus_pkg.sv
// Shared types and constants for the MAX bus controller: Ultimax region map, read-mux select, stall threshold.
// Pure definitions, no state.
package max_bus_pkg;

    typedef enum logic [2:0] {
        CS_NONE,
        CS_RAM,
        CS_COL,
        CS_VIC,
        CS_SID,
        CS_CIA,
        CS_ROML,
        CS_ROMH
    } cs_t;

    localparam logic [15:0] ROML_BASE = 16'h8000;
    localparam logic [15:0] ROML_MASK = 16'hE000;
    localparam logic [15:0] VIC_BASE  = 16'hD000;
    localparam logic [15:0] VIC_MASK  = 16'hFC00;
    localparam logic [15:0] SID_BASE  = 16'hD400;
    localparam logic [15:0] SID_MASK  = 16'hFC00;
    localparam logic [15:0] COL_BASE  = 16'hD800;
    localparam logic [15:0] COL_MASK  = 16'hFC00;
    localparam logic [15:0] CIA_BASE  = 16'hDC00;
    localparam logic [15:0] CIA_MASK  = 16'hFF00;
    localparam logic [15:0] ROMH_BASE = 16'hE000;
    localparam logic [15:0] ROMH_MASK = 16'hE000;

    localparam logic [1:0] BA_STALL_TH = 2'd3;

    // RAM is tested first so an expanded RAM shadows any region it overlaps.
    function automatic cs_t decode_addr(input logic [15:0] a, input int unsigned ram_aw);
        cs_t sel;
        sel = CS_NONE;
        if ({16'd0, a} < (32'd1 << ram_aw))        sel = CS_RAM;
        else if ((a & ROML_MASK) == ROML_BASE)     sel = CS_ROML;
        else if ((a & VIC_MASK)  == VIC_BASE)      sel = CS_VIC;
        else if ((a & SID_MASK)  == SID_BASE)      sel = CS_SID;
        else if ((a & COL_MASK)  == COL_BASE)      sel = CS_COL;
        else if ((a & CIA_MASK)  == CIA_BASE)      sel = CS_CIA;
        else if ((a & ROMH_MASK) == ROMH_BASE)     sel = CS_ROMH;
        return sel;
    endfunction

endpackage

// File: rtl/max_clk_phase.sv
// Phase counter for one phi2 period plus phi0 and the VIC/pixel/CPU-slot strobes.
// Strobes are combinational from the registered phase; no backpressure, hold_i parks the phase at 0.
module max_clk_phase #(
    parameter int unsigned CLK_DIV = 32,
    parameter int unsigned PIX_DIV = 4,
    parameter int unsigned PH_W    = $clog2(CLK_DIV)
) (
    input  logic            clk_i,
    input  logic            hold_i,
    input  logic            run_i,
    output logic [PH_W-1:0] ph_o,
    output logic            phi0_o,
    output logic            vic_en_o,
    output logic            pix_en_o,
    output logic            cpu_slot_o
);

    logic [PH_W-1:0] ph_q, ph_d;

    always_comb begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PH_W'(CLK_DIV - 1)) ph_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (hold_i) ph_q <= '0;
        else        ph_q <= ph_d;
    end

    assign ph_o       = ph_q;
    assign phi0_o     = (ph_q >= PH_W'(CLK_DIV / 2));
    assign vic_en_o   = run_i & (ph_q == PH_W'(CLK_DIV / 2 - 1));
    assign pix_en_o   = run_i & ((32'(ph_q) % 32'(PIX_DIV)) == 32'(PIX_DIV - 1));
    assign cpu_slot_o = run_i & (ph_q == PH_W'(CLK_DIV - 1));

endmodule

// File: rtl/max_bus_ctrl.sv
// MAX bus controller: reset stretcher, BA-aware CPU enable, registered Ultimax decode and CPU read mux.
// Decode loads at ph 0, read data at ph CLK_DIV-2; VIC backpressure via ba stalls cpu_en.
module max_bus_ctrl
    import max_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 32,
    parameter int unsigned PIX_DIV    = 4,
    parameter int unsigned RAM_AW     = 11,
    parameter int unsigned RST_CYCLES = 255
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        ba,
    input  logic [7:0]  ram_do,
    input  logic [7:0]  vic_do,
    input  logic [7:0]  sid_do,
    input  logic [7:0]  cia_do,
    input  logic [7:0]  roml_do,
    input  logic [7:0]  romh_do,
    input  logic [3:0]  col_do,
    output logic        sys_reset,
    output logic        phi0,
    output logic        cpu_en,
    output logic        vic_en,
    output logic        pix_en,
    output logic        io_rd,
    output logic        cs_ram,
    output logic        cs_col,
    output logic        cs_vic,
    output logic        cs_sid,
    output logic        cs_cia,
    output logic        cs_roml,
    output logic        cs_romh,
    output logic        ram_we,
    output logic        col_we,
    output logic        io_we,
    output logic [7:0]  cpu_di
);

    localparam int unsigned PH_W = $clog2(CLK_DIV);
    localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

    logic [RC_W-1:0] rc_q, rc_d;
    logic            sys_reset_q;
    cs_t             sel_q, sel_d;
    logic [1:0]      ba_cnt_q, ba_cnt_d;
    logic [7:0]      cpu_di_q, cpu_di_d;
    logic [PH_W-1:0] ph;
    logic            cpu_slot;
    logic            stall;
    logic            is_io;

    max_clk_phase #(
        .CLK_DIV (CLK_DIV),
        .PIX_DIV (PIX_DIV),
        .PH_W    (PH_W)
    ) u_phase (
        .clk_i      (clk_cpu),
        .hold_i     (reset | sys_reset_q),
        .run_i      (~sys_reset_q),
        .ph_o       (ph),
        .phi0_o     (phi0),
        .vic_en_o   (vic_en),
        .pix_en_o   (pix_en),
        .cpu_slot_o (cpu_slot)
    );

    // Reads give way to the VIC at once; writes ride out the first three BA cycles.
    assign stall  = ~ba & (~we | (ba_cnt_q >= BA_STALL_TH));
    assign cpu_en = cpu_slot & ~stall;
    assign is_io  = (sel_q == CS_VIC) | (sel_q == CS_SID) | (sel_q == CS_CIA);

    always_comb begin
        rc_d = rc_q;
        if (rc_q != RC_W'(RST_CYCLES)) rc_d = rc_q + RC_W'(1);

        sel_d = sel_q;
        if (sys_reset_q)              sel_d = CS_NONE;
        else if (ph == PH_W'(0))      sel_d = decode_addr(addr, RAM_AW);

        ba_cnt_d = ba_cnt_q;
        if (ba)                                       ba_cnt_d = 2'd0;
        else if (vic_en && ba_cnt_q != BA_STALL_TH)   ba_cnt_d = ba_cnt_q + 2'd1;

        cpu_di_d = cpu_di_q;
        if (!sys_reset_q && ph == PH_W'(CLK_DIV - 2)) begin
            case (sel_q)
                CS_RAM:  cpu_di_d = ram_do;
                CS_COL:  cpu_di_d = {cpu_di_q[7:4], col_do};
                CS_VIC:  cpu_di_d = vic_do;
                CS_SID:  cpu_di_d = sid_do;
                CS_CIA:  cpu_di_d = cia_do;
                CS_ROML: cpu_di_d = roml_do;
                CS_ROMH: cpu_di_d = romh_do;
                default: cpu_di_d = cpu_di_q;
            endcase
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            rc_q        <= '0;
            sys_reset_q <= 1'b1;
            sel_q       <= CS_NONE;
            ba_cnt_q    <= 2'd0;
            cpu_di_q    <= 8'h00;
        end else begin
            rc_q        <= rc_d;
            sys_reset_q <= (rc_q != RC_W'(RST_CYCLES));
            sel_q       <= sel_d;
            ba_cnt_q    <= ba_cnt_d;
            cpu_di_q    <= cpu_di_d;
        end
    end

    assign sys_reset = sys_reset_q;
    assign cs_ram    = (sel_q == CS_RAM);
    assign cs_col    = (sel_q == CS_COL);
    assign cs_vic    = (sel_q == CS_VIC);
    assign cs_sid    = (sel_q == CS_SID);
    assign cs_cia    = (sel_q == CS_CIA);
    assign cs_roml   = (sel_q == CS_ROML);
    assign cs_romh   = (sel_q == CS_ROMH);
    assign ram_we    = cpu_en & we & cs_ram;
    assign col_we    = cpu_en & we & cs_col;
    assign io_we     = cpu_en & we & is_io;
    assign io_rd     = cpu_en & ~we & is_io;
    assign cpu_di    = cpu_di_q;

endmodule
